hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Parametrised hazard and forwarding controller for the pipelined processor, successor to the single-cycle combinational forwarding/stall unit. Sits beside the ID stage: it sources ALU operand forwarding selects, load-use stall/bubble, and branch flush, and adds a memory-wait freeze FSM with timeout detection and saturating stall/flush performance counters. All hazard outputs feed the PC, IF/ID and ID/EX pipeline register enables.

## Interface
- REG_AW, 3, register address width (2**REG_AW architectural registers)
- ZERO_REG, 1, 1 = register 0 is hardwired zero and never forwarded or hazard-checked
- MAX_WAIT, 15, memory-wait cycles before timeout_err sets (>=1)
- CNT_W, 16, width of the performance counters
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high
- rs, rt  in  REG_AW  source registers of the instruction in ID
- rs_used, rt_used  in  1  source actually read by that instruction
- ex_rd, mem_rd, wb_rd  in  REG_AW  destinations in EX, MEM, WB
- ex_regwr, mem_regwr, wb_regwr  in  1  stage will write its destination
- ex_memrd, mem_memrd  in  1  instruction in EX / MEM is a load
- mem_ready  in  1  data memory has returned load data this cycle
- branch_taken  in  1  branch resolved taken in EX
- fwd_a, fwd_b  out  2  00 regfile, 01 EX, 10 MEM, 11 WB
- stall  out  1  hold PC and IF/ID
- bubble  out  1  load NOP into ID/EX
- flush  out  1  kill IF/ID and ID/EX
- freeze  out  1  hold all pipeline registers
- timeout_err  out  1  sticky, memory wait exceeded MAX_WAIT
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters

## Operation
- Forwarding (combinational, per operand): match requires used flag, stage regwr, equal address, and (ZERO_REG=0 or address != 0). Priority EX > MEM > WB > regfile.
- Load-use: hazard = ex_memrd && ex_regwr && matching operand forwarded from EX (01). Asserts stall=1, bubble=1.
- Flush: flush = branch_taken. Flush beats load-use: when both, flush=1, stall=bubble=0.
- Freeze beats everything: while freeze=1, stall, bubble and flush are forced 0 (EX is held, so the branch is re-presented after the freeze).
- FSM states RUN, MEM_WAIT; wait_cnt is ceil(log2(MAX_WAIT+1)) bits.
- RUN: freeze = mem_memrd && !mem_ready. If set, go MEM_WAIT, wait_cnt <= 1.
- MEM_WAIT: freeze = !mem_ready. On mem_ready go RUN; freeze drops in that same cycle. Otherwise wait_cnt increments, saturating at MAX_WAIT; when wait_cnt == MAX_WAIT and !mem_ready, timeout_err <= 1. The FSM keeps freezing; no recovery other than reset.
- stall_cnt increments each cycle with stall || freeze. flush_cnt increments each cycle with flush. Both saturate at all-ones and never wrap.

## Timing
- fwd_*, stall, bubble, flush and freeze are combinational, valid in the same cycle as their inputs; zero-cycle latency.
- Registered state, counters and flags update on the rising clk edge.
- Reset (asynchronous, any time, including mid-wait): state=RUN, wait_cnt=0, timeout_err=0, stall_cnt=flush_cnt=0. Combinational outputs then follow their inputs.
- Counters become visible one cycle after the counted event.

## Structure
- Shared package hazard_pkg holds the fwd select constants (FWD_RF, FWD_EX, FWD_MEM, FWD_WB) and the state enum (ST_RUN, ST_MEM_WAIT).
- One sub-module, fwd_sel, instantiated once per operand: address-compare and priority-encode for a single source.
- FSM, freeze, timeout and counters live in the top-level module.

## Test plan
- rs=2 used, ex_rd=2 ex_regwr=1, mem_rd=2 mem_regwr=1 -> fwd_a=01. Repeat with rs=0, ZERO_REG=1 -> fwd_a=00.
- ex_memrd=1, ex_rd=3, rt=3 used -> stall=bubble=1 for one cycle, stall_cnt=1 next cycle. Add branch_taken=1 in the same cycle -> flush=1, stall=0.
- mem_memrd=1, mem_ready low for 4 cycles then high -> freeze=1 for exactly 4 cycles, 0 in the cycle ready rises. State returns to RUN; stall_cnt=4.
- MAX_WAIT=15, mem_ready held low 20 cycles -> timeout_err=1 from the cycle after wait_cnt reaches 15, freeze stays 1. Assert reset -> timeout_err=0 immediately.
- Drive flush for 2**CNT_W+5 cycles (CNT_W=4: 21 cycles) -> flush_cnt saturates at 15 and does not wrap.
- Assert reset mid-MEM_WAIT while mem_ready=0 and mem_memrd=1 -> state RUN. After reset release, freeze=1 re-evaluates from RUN with wait_cnt restarting at 1.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding controller: operand forwarding
// selects and the memory-wait FSM state encoding.
package hazard_pkg;

    typedef logic [1:0] fwd_t;

    localparam fwd_t FWD_RF  = 2'b00;
    localparam fwd_t FWD_EX  = 2'b01;
    localparam fwd_t FWD_MEM = 2'b10;
    localparam fwd_t FWD_WB  = 2'b11;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle for the hazard controller: ID sources, downstream
// destinations, memory handshake, and the resulting hazard controls/counters.
interface hazard_ctrl_if #(
    parameter int REG_AW = 3,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              rs_used;
    logic              rt_used;
    logic [REG_AW-1:0] ex_rd;
    logic [REG_AW-1:0] mem_rd;
    logic [REG_AW-1:0] wb_rd;
    logic              ex_regwr;
    logic              mem_regwr;
    logic              wb_regwr;
    logic              ex_memrd;
    logic              mem_memrd;
    logic              mem_ready;
    logic              branch_taken;

    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              stall;
    logic              bubble;
    logic              flush;
    logic              freeze;
    logic              timeout_err;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output rs, rt, rs_used, rt_used,
        output ex_rd, mem_rd, wb_rd,
        output ex_regwr, mem_regwr, wb_regwr,
        output ex_memrd, mem_memrd, mem_ready, branch_taken,
        input  fwd_a, fwd_b, stall, bubble, flush, freeze,
        input  timeout_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  rs, rt, rs_used, rt_used,
        input  ex_rd, mem_rd, wb_rd,
        input  ex_regwr, mem_regwr, wb_regwr,
        input  ex_memrd, mem_memrd, mem_ready, branch_taken,
        output fwd_a, fwd_b, stall, bubble, flush, freeze,
        output timeout_err, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/fwd_sel.sv
// Forwarding select for one source operand: compares against EX/MEM/WB
// destinations and picks the youngest producer.
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 3,
    parameter int ZERO_REG = 1
) (
    input  logic [REG_AW-1:0] src,
    input  logic              src_used,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_regwr,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwr,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_regwr,
    output fwd_t              sel
);

    logic src_live;
    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    // A hardwired-zero source never needs a bypass, whatever writes r0.
    assign src_live = src_used && ((ZERO_REG == 0) || (src != '0));

    assign ex_hit  = src_live && ex_regwr  && (ex_rd  == src);
    assign mem_hit = src_live && mem_regwr && (mem_rd == src);
    assign wb_hit  = src_live && wb_regwr  && (wb_rd  == src);

    always_comb begin
        sel = FWD_RF;
        if (ex_hit) begin
            sel = FWD_EX;
        end else if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: operand forwarding, load-use stall, branch flush,
// memory-wait freeze FSM with sticky timeout, and saturating event counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 3,
    parameter int ZERO_REG = 1,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave bus
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [REG_AW-1:0] src_arr  [2];
    logic              used_arr [2];
    fwd_t              sel_arr  [2];

    assign src_arr[0]  = bus.rs;
    assign src_arr[1]  = bus.rt;
    assign used_arr[0] = bus.rs_used;
    assign used_arr[1] = bus.rt_used;

    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        fwd_sel #(
            .REG_AW   (REG_AW),
            .ZERO_REG (ZERO_REG)
        ) u_fwd_sel (
            .src       (src_arr[gi]),
            .src_used  (used_arr[gi]),
            .ex_rd     (bus.ex_rd),
            .ex_regwr  (bus.ex_regwr),
            .mem_rd    (bus.mem_rd),
            .mem_regwr (bus.mem_regwr),
            .wb_rd     (bus.wb_rd),
            .wb_regwr  (bus.wb_regwr),
            .sel       (sel_arr[gi])
        );
    end

    assign bus.fwd_a = sel_arr[0];
    assign bus.fwd_b = sel_arr[1];

    // Freeze FSM state and counters
    state_t            state_reg,       state_next;
    logic [WAIT_W-1:0] wait_cnt_reg,    wait_cnt_next;
    logic              timeout_reg,     timeout_next;
    logic [CNT_W-1:0]  stall_cnt_reg,   stall_cnt_next;
    logic [CNT_W-1:0]  flush_cnt_reg,   flush_cnt_next;

    logic load_use;
    logic freeze;
    logic stall;
    logic bubble;
    logic flush;

    // Only an EX-stage load that the ID instruction would bypass from EX needs a bubble.
    assign load_use = bus.ex_memrd && bus.ex_regwr &&
                      ((sel_arr[0] == FWD_EX) || (sel_arr[1] == FWD_EX));

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        timeout_next  = timeout_reg;
        freeze        = 1'b0;
        case (state_reg)
            ST_RUN: begin
                if (bus.mem_memrd && !bus.mem_ready) begin
                    freeze        = 1'b1;
                    state_next    = ST_MEM_WAIT;
                    wait_cnt_next = WAIT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (bus.mem_ready) begin
                    state_next = ST_RUN;
                end else begin
                    freeze = 1'b1;
                    if (wait_cnt_reg == WAIT_MAX) begin
                        timeout_next = 1'b1;
                    end else begin
                        wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
                    end
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // Freeze holds EX, so a branch or load-use seen now is re-presented later.
    assign flush  = bus.branch_taken && !freeze;
    assign stall  = load_use && !bus.branch_taken && !freeze;
    assign bubble = stall;

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        flush_cnt_next = flush_cnt_reg;
        if ((stall || freeze) && (stall_cnt_reg != '1)) begin
            stall_cnt_next = stall_cnt_reg + CNT_W'(1);
        end
        if (flush && (flush_cnt_reg != '1)) begin
            flush_cnt_next = flush_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_RUN;
            wait_cnt_reg  <= '0;
            timeout_reg   <= 1'b0;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            wait_cnt_reg  <= wait_cnt_next;
            timeout_reg   <= timeout_next;
            stall_cnt_reg <= stall_cnt_next;
            flush_cnt_reg <= flush_cnt_next;
        end
    end

    assign bus.stall       = stall;
    assign bus.bubble      = bubble;
    assign bus.flush       = flush;
    assign bus.freeze      = freeze;
    assign bus.timeout_err = timeout_reg;
    assign bus.stall_cnt   = stall_cnt_reg;
    assign bus.flush_cnt   = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (REG_AW=3, ZERO_REG=1,
// MAX_WAIT=15, CNT_W=4 so counter saturation is reachable).
module tb_hazard_ctrl;

    localparam int REG_AW   = 3;
    localparam int ZERO_REG = 1;
    localparam int MAX_WAIT = 15;
    localparam int CNT_W    = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;

    int checks   = 0;
    int failures = 0;

    hazard_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

    hazard_ctrl #(
        .REG_AW   (REG_AW),
        .ZERO_REG (ZERO_REG),
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        bus.rs = '0; bus.rt = '0; bus.rs_used = 1'b0; bus.rt_used = 1'b0;
        bus.ex_rd = '0; bus.mem_rd = '0; bus.wb_rd = '0;
        bus.ex_regwr = 1'b0; bus.mem_regwr = 1'b0; bus.wb_regwr = 1'b0;
        bus.ex_memrd = 1'b0; bus.mem_memrd = 1'b0; bus.mem_ready = 1'b0;
        bus.branch_taken = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic set_fwd(input logic [2:0] rs, input logic rs_used,
                           input logic [2:0] rt, input logic rt_used,
                           input logic [2:0] ex_rd, input logic ex_wr,
                           input logic [2:0] mem_rd, input logic mem_wr,
                           input logic [2:0] wb_rd, input logic wb_wr);
        bus.rs = rs; bus.rs_used = rs_used; bus.rt = rt; bus.rt_used = rt_used;
        bus.ex_rd = ex_rd; bus.ex_regwr = ex_wr;
        bus.mem_rd = mem_rd; bus.mem_regwr = mem_wr;
        bus.wb_rd = wb_rd; bus.wb_regwr = wb_wr;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        #3;
        checks++;
        if (bus.stall_cnt !== 4'd0 || bus.flush_cnt !== 4'd0 || bus.timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_regs: stall_cnt=%0d flush_cnt=%0d timeout=%b required 0/0/0",
                     bus.stall_cnt, bus.flush_cnt, bus.timeout_err);
        end
        checks++;
        if ({bus.freeze, bus.stall, bus.bubble, bus.flush, bus.fwd_a, bus.fwd_b} !== 8'b0) begin
            failures++;
            $display("FAIL reset_comb: freeze=%b stall=%b bubble=%b flush=%b fwd_a=%b fwd_b=%b required all 0",
                     bus.freeze, bus.stall, bus.bubble, bus.flush, bus.fwd_a, bus.fwd_b);
        end
        tick();
        reset = 1'b0;
        #1;
        $display("test_reset done");
    endtask

    task automatic test_forwarding();
        do_reset();
        // EX and MEM both match rs=2: EX wins
        set_fwd(3'd2, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 3'd2, 1'b1, 3'd0, 1'b0);
        checks++;
        if (bus.fwd_a !== 2'b01) begin
            failures++;
            $display("FAIL fwd_ex_priority: fwd_a=%b required 01", bus.fwd_a);
        end
        // rs=0 with hardwired zero: never forwarded
        set_fwd(3'd0, 1'b1, 3'd0, 1'b1, 3'd0, 1'b1, 3'd0, 1'b1, 3'd0, 1'b1);
        checks++;
        if (bus.fwd_a !== 2'b00 || bus.fwd_b !== 2'b00) begin
            failures++;
            $display("FAIL fwd_zero_reg: fwd_a=%b fwd_b=%b required 00/00", bus.fwd_a, bus.fwd_b);
        end
        // MEM beats WB on rt; rs only in WB
        set_fwd(3'd4, 1'b1, 3'd5, 1'b1, 3'd1, 1'b1, 3'd5, 1'b1, 3'd5, 1'b1);
        checks++;
        if (bus.fwd_a !== 2'b00 || bus.fwd_b !== 2'b10) begin
            failures++;
            $display("FAIL fwd_mem_wb: fwd_a=%b fwd_b=%b required 00/10", bus.fwd_a, bus.fwd_b);
        end
        set_fwd(3'd4, 1'b1, 3'd5, 1'b1, 3'd1, 1'b1, 3'd6, 1'b1, 3'd4, 1'b1);
        checks++;
        if (bus.fwd_a !== 2'b11 || bus.fwd_b !== 2'b00) begin
            failures++;
            $display("FAIL fwd_wb: fwd_a=%b fwd_b=%b required 11/00", bus.fwd_a, bus.fwd_b);
        end
        // unused source or non-writing stage: no forward
        set_fwd(3'd7, 1'b0, 3'd7, 1'b1, 3'd7, 1'b1, 3'd7, 1'b0, 3'd7, 1'b0);
        checks++;
        if (bus.fwd_a !== 2'b00 || bus.fwd_b !== 2'b01) begin
            failures++;
            $display("FAIL fwd_used_regwr: fwd_a=%b fwd_b=%b required 00/01", bus.fwd_a, bus.fwd_b);
        end
        set_fwd(3'd3, 1'b1, 3'd3, 1'b1, 3'd3, 1'b0, 3'd3, 1'b0, 3'd3, 1'b1);
        checks++;
        if (bus.fwd_a !== 2'b11 || bus.fwd_b !== 2'b11) begin
            failures++;
            $display("FAIL fwd_regwr_gate: fwd_a=%b fwd_b=%b required 11/11", bus.fwd_a, bus.fwd_b);
        end
        clear_inputs();
        $display("test_forwarding done");
    endtask

    task automatic test_load_use();
        do_reset();
        bus.ex_memrd = 1'b1; bus.ex_regwr = 1'b1; bus.ex_rd = 3'd3;
        bus.rt = 3'd3; bus.rt_used = 1'b1;
        #1;
        checks++;
        if (bus.stall !== 1'b1 || bus.bubble !== 1'b1 || bus.flush !== 1'b0) begin
            failures++;
            $display("FAIL load_use: stall=%b bubble=%b flush=%b required 1/1/0",
                     bus.stall, bus.bubble, bus.flush);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (bus.stall !== 1'b0 || bus.stall_cnt !== 4'd1) begin
            failures++;
            $display("FAIL load_use_cnt: stall=%b stall_cnt=%0d required 0/1", bus.stall, bus.stall_cnt);
        end
        // load into a register the ID instruction does not read: no stall
        bus.ex_memrd = 1'b1; bus.ex_regwr = 1'b1; bus.ex_rd = 3'd3;
        bus.rt = 3'd3; bus.rt_used = 1'b0; bus.rs = 3'd2; bus.rs_used = 1'b1;
        #1;
        checks++;
        if (bus.stall !== 1'b0 || bus.bubble !== 1'b0) begin
            failures++;
            $display("FAIL load_use_unused: stall=%b bubble=%b required 0/0", bus.stall, bus.bubble);
        end
        // branch in the same cycle as a load-use: flush wins
        bus.rt_used = 1'b1; bus.branch_taken = 1'b1;
        #1;
        checks++;
        if (bus.flush !== 1'b1 || bus.stall !== 1'b0 || bus.bubble !== 1'b0) begin
            failures++;
            $display("FAIL flush_beats_load: flush=%b stall=%b bubble=%b required 1/0/0",
                     bus.flush, bus.stall, bus.bubble);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (bus.stall_cnt !== 4'd1 || bus.flush_cnt !== 4'd1) begin
            failures++;
            $display("FAIL flush_cnt: stall_cnt=%0d flush_cnt=%0d required 1/1", bus.stall_cnt, bus.flush_cnt);
        end
        $display("test_load_use done");
    endtask

    task automatic test_mem_wait();
        do_reset();
        bus.mem_memrd = 1'b1; bus.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                bus.branch_taken = 1'b1;
                bus.ex_memrd = 1'b1; bus.ex_regwr = 1'b1; bus.ex_rd = 3'd5;
                bus.rs = 3'd5; bus.rs_used = 1'b1;
            end else begin
                bus.branch_taken = 1'b0; bus.ex_memrd = 1'b0; bus.rs_used = 1'b0;
            end
            #1;
            checks++;
            if (bus.freeze !== 1'b1 || bus.stall !== 1'b0 || bus.bubble !== 1'b0 || bus.flush !== 1'b0) begin
                failures++;
                $display("FAIL freeze_cycle%0d: freeze=%b stall=%b bubble=%b flush=%b required 1/0/0/0",
                         i, bus.freeze, bus.stall, bus.bubble, bus.flush);
            end
            tick();
        end
        clear_inputs();
        bus.mem_memrd = 1'b1; bus.mem_ready = 1'b1;
        #1;
        checks++;
        if (bus.freeze !== 1'b0) begin
            failures++;
            $display("FAIL freeze_release: freeze=%b required 0", bus.freeze);
        end
        tick();
        // back in RUN: with no load in MEM a low ready must not freeze
        bus.mem_memrd = 1'b0; bus.mem_ready = 1'b0;
        #1;
        checks++;
        if (bus.freeze !== 1'b0 || bus.stall_cnt !== 4'd4 || bus.flush_cnt !== 4'd0) begin
            failures++;
            $display("FAIL mem_wait_end: freeze=%b stall_cnt=%0d flush_cnt=%0d required 0/4/0",
                     bus.freeze, bus.stall_cnt, bus.flush_cnt);
        end
        $display("test_mem_wait done");
    endtask

    task automatic run_to_timeout(input string tag);
        bus.mem_memrd = 1'b1; bus.mem_ready = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 15) begin
                checks++;
                if (bus.timeout_err !== 1'b0 || bus.freeze !== 1'b1) begin
                    failures++;
                    $display("FAIL %s_pre: timeout_err=%b freeze=%b after 15 cycles required 0/1",
                             tag, bus.timeout_err, bus.freeze);
                end
            end
            if (i == 16) begin
                checks++;
                if (bus.timeout_err !== 1'b1) begin
                    failures++;
                    $display("FAIL %s_set: timeout_err=%b after 16 cycles required 1", tag, bus.timeout_err);
                end
            end
        end
        checks++;
        if (bus.timeout_err !== 1'b1 || bus.freeze !== 1'b1 || bus.stall_cnt !== 4'd15) begin
            failures++;
            $display("FAIL %s_hold: timeout_err=%b freeze=%b stall_cnt=%0d required 1/1/15",
                     tag, bus.timeout_err, bus.freeze, bus.stall_cnt);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        run_to_timeout("timeout");
        reset = 1'b1;
        #1;
        checks++;
        if (bus.timeout_err !== 1'b0 || bus.stall_cnt !== 4'd0) begin
            failures++;
            $display("FAIL timeout_reset: timeout_err=%b stall_cnt=%0d required 0/0",
                     bus.timeout_err, bus.stall_cnt);
        end
        tick();
        reset = 1'b0;
        clear_inputs();
        #1;
        $display("test_timeout done");
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        bus.mem_memrd = 1'b1; bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b1;
        bus.mem_memrd = 1'b0;
        #1;
        // MEM_WAIT would still freeze on low ready; RUN does not without a load
        checks++;
        if (bus.freeze !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_wait_state: freeze=%b required 0", bus.freeze);
        end
        tick();
        reset = 1'b0;
        #1;
        run_to_timeout("restart");
        do_reset();
        $display("test_reset_mid_wait done");
    endtask

    task automatic test_flush_sat();
        do_reset();
        bus.branch_taken = 1'b1;
        for (int i = 1; i <= 21; i++) begin
            tick();
            if (i == 1 || i == 14 || i == 15 || i == 21) begin
                checks++;
                if (bus.flush_cnt !== ((i > 15) ? 4'd15 : 4'(i)) || bus.stall_cnt !== 4'd0) begin
                    failures++;
                    $display("FAIL flush_sat_%0d: flush_cnt=%0d stall_cnt=%0d required %0d/0",
                             i, bus.flush_cnt, bus.stall_cnt, (i > 15) ? 15 : i);
                end
            end
        end
        clear_inputs();
        $display("test_flush_sat done");
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        test_flush_sat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
